// File: rtl/energy_event_framer.sv
`default_nettype none
// ============================================================================
// Module      : energy_event_framer
// Description : Hysteresis qualifier and event framer for the energy detector
//               decision stream, with a first-word fall-through record FIFO.
//               Optional force-close timeout: define ED_EVENT_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module energy_event_framer #(
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] SR_ADDR_HYST = 8'd5,
    parameter logic [7:0] SR_ADDR_TMO  = 8'd6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [31:0] xk_d_fct_dt,
    input  logic        dv_d_fct_dt,
    output logic [31:0] ev_start_ts,
    output logic [31:0] ev_duration,
    output logic [30:0] ev_peak,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [15:0] ev_drop_cnt
);

    localparam int c_AW    = $clog2(FIFO_DEPTH);
    localparam int c_REC_W = 95;
    localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(FIFO_DEPTH);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ARMING    = 2'd1,
        S_ACTIVE    = 2'd2,
        S_RELEASING = 2'd3
    } state_t;

    state_t      r_state, w_state_eff, w_state_nxt;
    logic [31:0] r_ts;
    logic [31:0] r_start, w_start_nxt;
    logic [31:0] r_last, w_last_nxt;
    logic [30:0] r_peak, w_peak_nxt;
    logic [15:0] r_run, w_run_nxt;
    logic [15:0] r_miss, w_miss_nxt;
    logic [31:0] r_hyst;
    logic [15:0] w_on_cnt, w_off_cnt;
    logic        w_hit;
    logic [30:0] w_metric;
    logic        w_timeout;
    logic        w_close;

    assign w_hit     = xk_d_fct_dt[0];
    assign w_metric  = xk_d_fct_dt[31:1];
    assign w_on_cnt  = (r_hyst[15:0]  == 16'd0) ? 16'd1 : r_hyst[15:0];
    assign w_off_cnt = (r_hyst[31:16] == 16'd0) ? 16'd1 : r_hyst[31:16];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hyst <= '0;
        end else if (set_stb && (set_addr == SR_ADDR_HYST)) begin
            r_hyst <= set_data;
        end
    end

`ifdef ED_EVENT_TIMEOUT_EN
    logic [31:0] r_max_len;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_max_len <= '0;
        end else if (set_stb && (set_addr == SR_ADDR_TMO)) begin
            r_max_len <= set_data;
        end
    end

    // Expiry closes the open event with its existing hits; the sample itself
    // is then handled as if the framer were already idle.
    assign w_timeout = dv_d_fct_dt && (r_max_len != 32'd0) &&
                       ((r_state == S_ACTIVE) || (r_state == S_RELEASING)) &&
                       ((r_ts - r_start) >= r_max_len);
`else
    logic w_unused_tmo_addr;
    assign w_unused_tmo_addr = ^SR_ADDR_TMO;
    assign w_timeout         = 1'b0;
`endif

    assign w_state_eff = w_timeout ? S_IDLE : r_state;

    always_comb begin
        w_state_nxt = w_state_eff;
        w_start_nxt = r_start;
        w_last_nxt  = r_last;
        w_peak_nxt  = r_peak;
        w_run_nxt   = r_run;
        w_miss_nxt  = r_miss;
        w_close     = w_timeout;
        if (dv_d_fct_dt) begin
            if (w_hit && (w_state_eff != S_IDLE)) begin
                w_last_nxt = r_ts;
                if (w_metric > r_peak) begin
                    w_peak_nxt = w_metric;
                end
            end
            unique case (w_state_eff)
                S_IDLE: begin
                    if (w_hit) begin
                        w_start_nxt = r_ts;
                        w_last_nxt  = r_ts;
                        w_peak_nxt  = w_metric;
                        w_run_nxt   = 16'd1;
                        w_state_nxt = (w_on_cnt == 16'd1) ? S_ACTIVE : S_ARMING;
                    end
                end
                S_ARMING: begin
                    if (w_hit) begin
                        w_run_nxt = r_run + 16'd1;
                        // >= keeps a live lowering of on_cnt from stranding the candidate
                        if ((r_run + 16'd1) >= w_on_cnt) begin
                            w_state_nxt = S_ACTIVE;
                        end
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_ACTIVE: begin
                    if (!w_hit) begin
                        w_miss_nxt = 16'd1;
                        if (w_off_cnt == 16'd1) begin
                            w_close     = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_state_nxt = S_RELEASING;
                        end
                    end
                end
                S_RELEASING: begin
                    if (w_hit) begin
                        w_miss_nxt  = 16'd0;
                        w_state_nxt = S_ACTIVE;
                    end else begin
                        w_miss_nxt = r_miss + 16'd1;
                        if ((r_miss + 16'd1) >= w_off_cnt) begin
                            w_close     = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ts    <= '0;
            r_start <= '0;
            r_last  <= '0;
            r_peak  <= '0;
            r_run   <= '0;
            r_miss  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_start <= w_start_nxt;
            r_last  <= w_last_nxt;
            r_peak  <= w_peak_nxt;
            r_run   <= w_run_nxt;
            r_miss  <= w_miss_nxt;
            if (dv_d_fct_dt) begin
                r_ts <= r_ts + 32'd1;
            end
        end
    end

    // Event record FIFO, first-word fall-through.
    logic [c_REC_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [c_AW:0]      r_count;
    logic [15:0]        r_drop_cnt;
    logic [c_REC_W-1:0] w_rec;
    logic               w_full, w_pop, w_push, w_drop;

    assign w_rec  = {r_start, r_last - r_start + 32'd1, r_peak};
    assign w_full = (r_count == c_FULL);
    assign w_pop  = ev_valid && ev_ready;
    assign w_push = w_close && (!w_full || w_pop);
    assign w_drop = w_close && w_full && !w_pop;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_rec;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign {ev_start_ts, ev_duration, ev_peak} = r_mem[r_rd_ptr];
    assign ev_valid    = (r_count != '0);
    assign ev_drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_energy_event_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_energy_event_framer
// Description : Directed plus randomized bench for energy_event_framer with a
//               burst-level reference model of the event framing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_energy_event_framer;

    localparam int c_DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = '0;
    logic [31:0] set_data = '0;
    logic [31:0] xk_d_fct_dt = '0;
    logic        dv_d_fct_dt = 1'b0;
    logic [31:0] ev_start_ts, ev_duration;
    logic [30:0] ev_peak;
    logic        ev_valid;
    logic        ev_ready = 1'b0;
    logic [15:0] ev_drop_cnt;

    energy_event_framer #(
        .FIFO_DEPTH  (c_DEPTH),
        .SR_ADDR_HYST(8'd5),
        .SR_ADDR_TMO (8'd6)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .set_stb    (set_stb),
        .set_addr   (set_addr),
        .set_data   (set_data),
        .xk_d_fct_dt(xk_d_fct_dt),
        .dv_d_fct_dt(dv_d_fct_dt),
        .ev_start_ts(ev_start_ts),
        .ev_duration(ev_duration),
        .ev_peak    (ev_peak),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_drop_cnt(ev_drop_cnt)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: event = run of on_cnt consecutive hits, ended by
    // off_cnt consecutive misses or by the length limit.
    typedef struct {
        bit [31:0] s;
        bit [31:0] d;
        bit [30:0] p;
    } rec_t;

    rec_t      mq[$];
    bit [31:0] m_ts, m_start, m_last, m_hyst, m_tmo;
    bit [30:0] m_peak;
    bit        m_in_event;
    int        m_hits, m_misses;
    bit [15:0] m_drop;

    function automatic int on_cnt();
        return (m_hyst[15:0] == 0) ? 1 : int'(m_hyst[15:0]);
    endfunction

    function automatic int off_cnt();
        return (m_hyst[31:16] == 0) ? 1 : int'(m_hyst[31:16]);
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_ts = 0; m_start = 0; m_last = 0; m_peak = 0; m_hyst = 0; m_tmo = 0;
        m_in_event = 0; m_hits = 0; m_misses = 0; m_drop = 0;
    endfunction

    function automatic void model_sample(input bit flag, input bit [30:0] metric,
                                         output bit closed, output rec_t rec);
        closed = 0;
        rec = '{0, 0, 0};
        if (m_in_event && m_tmo != 0 && (m_ts - m_start) >= m_tmo) begin
            closed = 1;
            rec = '{m_start, m_last - m_start + 32'd1, m_peak};
            m_in_event = 0; m_hits = 0; m_misses = 0;
        end
        if (flag) begin
            m_misses = 0;
            if (!m_in_event && m_hits == 0) begin
                m_start = m_ts;
                m_peak  = metric;
            end else if (metric > m_peak) begin
                m_peak = metric;
            end
            m_last = m_ts;
            m_hits++;
            if (!m_in_event && m_hits >= on_cnt()) m_in_event = 1;
        end else begin
            m_hits = 0;
            if (m_in_event) begin
                m_misses++;
                if (m_misses >= off_cnt()) begin
                    closed = 1;
                    rec = '{m_start, m_last - m_start + 32'd1, m_peak};
                    m_in_event = 0; m_misses = 0;
                end
            end
        end
    endfunction

    function automatic void model_edge(input bit dv, input bit flag, input bit [30:0] metric,
                                       input bit rdy, input bit stb, input bit [7:0] addr,
                                       input bit [31:0] data);
        int   size_before = mq.size();
        bit   pop = (size_before != 0) && rdy;
        bit   closed = 0;
        rec_t rec;
        if (dv) model_sample(flag, metric, closed, rec);
        if (pop) void'(mq.pop_front());
        if (closed) begin
            if (size_before < c_DEPTH || pop) mq.push_back(rec);
            else if (m_drop != 16'hFFFF) m_drop++;
        end
        if (dv) m_ts++;
        if (stb && addr == 8'd5) m_hyst = data;
`ifdef ED_EVENT_TIMEOUT_EN
        if (stb && addr == 8'd6) m_tmo = data;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("ev_valid", {31'd0, ev_valid}, {31'd0, mq.size() != 0});
        if (mq.size() != 0) begin
            chk("ev_start_ts", ev_start_ts, mq[0].s);
            chk("ev_duration", ev_duration, mq[0].d);
            chk("ev_peak", {1'b0, ev_peak}, {1'b0, mq[0].p});
        end
        chk("ev_drop_cnt", {16'd0, ev_drop_cnt}, {16'd0, m_drop});
    endtask

    task automatic cycle(input bit dv, input bit flag, input bit [30:0] metric,
                         input bit stb = 0, input bit [7:0] addr = 0, input bit [31:0] data = 0);
        dv_d_fct_dt = dv;
        xk_d_fct_dt = {metric, flag};
        set_stb     = stb;
        set_addr    = addr;
        set_data    = data;
        @(posedge clock);
        model_edge(dv, flag, metric, ev_ready, stb, addr, data);
        #1;
        dv_d_fct_dt = 1'b0;
        set_stb     = 1'b0;
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        dv_d_fct_dt = 1'b0;
        set_stb = 1'b0;
        @(posedge clock);
        model_reset();
        #1;
        reset = 1'b0;
    endtask

    task automatic write_reg(input bit [7:0] addr, input bit [31:0] data);
        cycle(0, 0, 0, 1, addr, data);
    endtask

    initial begin
        bit [30:0] hit_m[4] = '{31'd5, 31'd9, 31'd7, 31'd2};
        bit        flags[7] = '{0, 1, 1, 1, 1, 0, 0};
        int        k;

        // Reset values
        do_reset();
        chk("rst_valid", {31'd0, ev_valid}, 32'd0);
        chk("rst_start", ev_start_ts, 32'd0);
        chk("rst_dur", ev_duration, 32'd0);
        chk("rst_peak", {1'b0, ev_peak}, 32'd0);
        chk("rst_drop", {16'd0, ev_drop_cnt}, 32'd0);

        // Basic event: on=3, off=2
        ev_ready = 0;
        write_reg(8'd5, {16'd2, 16'd3});
        k = 0;
        for (int i = 0; i < 7; i++) begin
            cycle(1, flags[i], flags[i] ? hit_m[k] : 31'd0);
            if (flags[i]) k++;
            if (i == 5) chk("basic_not_yet", {31'd0, ev_valid}, 32'd0);
        end
        chk("basic_valid", {31'd0, ev_valid}, 32'd1);
        chk("basic_start", ev_start_ts, 32'd1);
        chk("basic_dur", ev_duration, 32'd4);
        chk("basic_peak", {1'b0, ev_peak}, 32'd9);
        ev_ready = 1;
        cycle(0, 0, 0);

        // Aborted arming
        cycle(1, 1, 31'd3);
        cycle(1, 1, 31'd4);
        cycle(1, 0, 31'd0);
        cycle(0, 0, 0);
        chk("abort_none", {31'd0, ev_valid}, 32'd0);

        // Release interrupted: on=3, off=3
        do_reset();
        ev_ready = 0;
        write_reg(8'd5, {16'd3, 16'd3});
        for (int i = 0; i < 9; i++) cycle(1, (i < 3) || (i == 5), 31'(i + 1));
        chk("rel_valid", {31'd0, ev_valid}, 32'd1);
        chk("rel_start", ev_start_ts, 32'd0);
        chk("rel_dur", ev_duration, 32'd6);
        ev_ready = 1;
        cycle(0, 0, 0);

        // FIFO overflow: five one-sample events with the consumer stalled
        ev_ready = 0;
        write_reg(8'd5, {16'd1, 16'd1});
        for (int i = 0; i < 5; i++) begin
            cycle(1, 1, 31'(10 + i));
            cycle(1, 0, 31'd0);
        end
        chk("ovf_drop", {16'd0, ev_drop_cnt}, 32'd1);
        ev_ready = 1;
        for (int i = 0; i < 5; i++) cycle(0, 0, 0);
        chk("ovf_drained", {31'd0, ev_valid}, 32'd0);

        // Reset in the middle of an active event
        cycle(1, 1, 31'd6);
        cycle(1, 1, 31'd8);
        do_reset();
        chk("midrst_valid", {31'd0, ev_valid}, 32'd0);
        ev_ready = 0;
        cycle(1, 0, 31'd0);
        cycle(1, 1, 31'd2);
        cycle(1, 0, 31'd0);
        chk("midrst_start", ev_start_ts, 32'd1);
        chk("midrst_dur", ev_duration, 32'd1);

`ifdef ED_EVENT_TIMEOUT_EN
        // Length limit with continuous hits
        do_reset();
        ev_ready = 1;
        write_reg(8'd6, 32'd4);
        for (int i = 0; i < 14; i++) cycle(1, 1, 31'(i));
`endif

        // Randomized traffic with live setting changes
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            bit        stb  = ($urandom_range(0, 19) == 0);
            bit [7:0]  addr = 8'($urandom_range(5, 7));
            bit [31:0] data = (addr == 8'd6) ? 32'($urandom_range(0, 6))
                                             : {16'($urandom_range(0, 4)), 16'($urandom_range(0, 4))};
            ev_ready = ($urandom_range(0, 1) == 1);
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                  31'($urandom_range(0, 15)), stb, addr, data);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
